seq_array_selector: RTL and testbench

- Multi-channel array selector: K channels each pick one W-bit element out of a SIZE-entry data array using a per-channel address.
- Channels are processed sequentially, LANES channels per clock, behind a start/busy/done handshake. Shared selector logic is time-multiplexed instead of instantiated K times.
- Adds two features: a relative-address mode with wrap-around, and per-channel out-of-range error flags.
- Sits between the array producer and downstream compare/sort stages of the CA2 datapath.

---
 rtl/seq_array_selector.sv | 155 +++++++++++++++
 tb/tb_seq_array_selector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_array_selector.sv
// Sequential multi-channel array selector: K channels pick one W-bit entry each,
// LANES channels per clock, with optional base-relative wrap-around addressing.
module seq_array_selector #(
  parameter int SIZE  = 16,
  parameter int K     = 4,
  parameter int W     = 8,
  parameter int LANES = 1,
  localparam int AW   = $clog2(SIZE),
  localparam int G    = K / LANES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [AW-1:0]     base,
  input  logic [W*SIZE-1:0] data_array,
  input  logic [AW*K-1:0]   address_array,
  output logic              busy,
  output logic              done,
  output logic [W*K-1:0]    sel_array,
  output logic [K-1:0]      err_flags
);

  localparam int            GW      = (G > 1) ? $clog2(G) : 1;
  localparam logic [AW:0]   SIZE_W  = (AW+1)'(SIZE);
  localparam logic [GW-1:0] LAST_G  = GW'(G - 1);

  if (K % LANES != 0) begin : g_lanes_check
    $error("seq_array_selector: K must be a multiple of LANES");
  end
  if (SIZE < 2) begin : g_size_check
    $error("seq_array_selector: SIZE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          busy_d, done_d;
  logic          cap_en;

  logic [W*SIZE-1:0] data_p0;
  logic [AW*K-1:0]   addr_p0;
  logic              mode_p0;
  logic [AW-1:0]     base_p0;

  logic [AW-1:0] lane_addr [LANES];
  logic [AW-1:0] lane_ea   [LANES];
  logic          lane_err  [LANES];
  logic [W-1:0]  lane_res  [LANES];

  // Returns {err, ea}; the relative wrap is only meaningful for in-range operands.
  function automatic logic [AW:0] eff_addr(input logic m, input logic [AW-1:0] a,
                                           input logic [AW-1:0] b);
    logic [AW:0]   sum;
    logic [AW-1:0] ea;
    logic          err;
    err = ({1'b0, a} >= SIZE_W) || (m && ({1'b0, b} >= SIZE_W));
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= SIZE_W) ea = AW'(sum - SIZE_W);
    else               ea = AW'(sum);
    if (!m) ea = a;
    return {err, ea};
  endfunction

  // Control: two-process FSM with registered busy/done.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    busy_d  = busy;
    done_d  = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cap_en  = 1'b1;
          grp_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        grp_d = grp_q + 1'b1;
        if (grp_q == LAST_G) begin
          grp_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grp_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Stage p0 -> lanes: shared resolvers look up the current group's channels.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_addr[l] = addr_p0[(int'(grp_q) * LANES + l) * AW +: AW];
      {lane_err[l], lane_ea[l]} = eff_addr(mode_p0, lane_addr[l], base_p0);
      lane_res[l] = '0;
      if (!lane_err[l]) begin
        for (int j = 0; j < SIZE; j++) begin
          if (lane_ea[l] == AW'(j)) lane_res[l] = data_p0[j*W +: W];
        end
      end
    end
  end

  // Capture on accepted start; write back one group per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0   <= '0;
      addr_p0   <= '0;
      mode_p0   <= 1'b0;
      base_p0   <= '0;
      sel_array <= '0;
      err_flags <= '0;
    end else if (cap_en) begin
      data_p0   <= data_array;
      addr_p0   <= address_array;
      mode_p0   <= mode;
      base_p0   <= base;
      sel_array <= '0;
      err_flags <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < K; i++) begin
        if (GW'(i / LANES) == grp_q) begin
          sel_array[i*W +: W] <= lane_res[i % LANES];
          err_flags[i]        <= lane_err[i % LANES];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_array_selector.sv
// Bench for seq_array_selector: three configurations (SIZE 16/12, LANES 1/2) share
// stimulus; table vectors, random ops vs an arithmetic model, and timing corners.
module tb_seq_array_selector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, mode;
  logic [3:0]   base;
  logic [127:0] data_array;
  logic [15:0]  address_array;

  logic         busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [31:0]  sel_a, sel_b, sel_c;
  logic [3:0]   err_a, err_b, err_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_array_selector #(.SIZE(16), .K(4), .W(8), .LANES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base),
    .data_array(data_array), .address_array(address_array),
    .busy(busy_a), .done(done_a), .sel_array(sel_a), .err_flags(err_a));

  seq_array_selector #(.SIZE(12), .K(4), .W(8), .LANES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base),
    .data_array(data_array[95:0]), .address_array(address_array),
    .busy(busy_b), .done(done_b), .sel_array(sel_b), .err_flags(err_b));

  seq_array_selector #(.SIZE(16), .K(4), .W(8), .LANES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base),
    .data_array(data_array), .address_array(address_array),
    .busy(busy_c), .done(done_c), .sel_array(sel_c), .err_flags(err_c));

  typedef struct {
    logic        mode;
    logic [3:0]  base;
    logic [15:0] adr;
    logic [31:0] sel16;
    logic [3:0]  err16;
    logic [31:0] sel12;
    logic [3:0]  err12;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: effective address straight from the modular-arithmetic definition.
  function automatic void model(input int size, input logic m, input logic [3:0] b,
                                input logic [15:0] adr, input logic [127:0] d,
                                output logic [31:0] sel, output logic [3:0] err);
    sel = '0;
    err = '0;
    for (int i = 0; i < 4; i++) begin
      int a, e;
      a = int'(adr[i*4 +: 4]);
      if (a >= size || (m && int'(b) >= size)) err[i] = 1'b1;
      else begin
        e = m ? (a + int'(b)) % size : a;
        sel[i*8 +: 8] = d[e*8 +: 8];
      end
    end
  endfunction

  task automatic scramble();
    address_array = 16'($urandom);
    data_array    = {$urandom, $urandom, $urandom, $urandom};
    mode          = 1'($urandom);
    base          = 4'($urandom);
  endtask

  // Pulse start at edge 0, then scramble inputs and watch 8 cycles.
  task automatic run_op(input string nm, input logic [31:0] e16, input logic [3:0] r16,
                        input logic [31:0] e12, input logic [3:0] r12, input bit glitch);
    int fa, fb, fc, na, nb, nc;
    bit busy_bad;
    fa = 0; fb = 0; fc = 0; na = 0; nb = 0; nc = 0; busy_bad = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = glitch;
    scramble();
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 1) begin
        check({nm, " partial_sel"}, {32'h0, sel_a}, {32'h0, 24'h0, e16[7:0]});
        check({nm, " partial_err"}, {60'h0, err_a}, {60'h0, 3'b000, r16[0]});
      end
      if (busy_a !== (c < 4) || busy_b !== (c < 4) || busy_c !== (c < 2)) busy_bad = 1;
      if (done_a === 1'b1) begin na++; if (fa == 0) fa = c; end
      if (done_b === 1'b1) begin nb++; if (fb == 0) fb = c; end
      if (done_c === 1'b1) begin nc++; if (fc == 0) fc = c; end
    end
    check({nm, " busy_seq"}, 64'(busy_bad), 64'd0);
    check({nm, " done_a"}, {32'(fa), 32'(na)}, {32'd4, 32'd1});
    check({nm, " done_b"}, {32'(fb), 32'(nb)}, {32'd4, 32'd1});
    check({nm, " done_c"}, {32'(fc), 32'(nc)}, {32'd2, 32'd1});
    check({nm, " sel16"}, {28'h0, err_a, sel_a}, {28'h0, r16, e16});
    check({nm, " sel12"}, {28'h0, err_b, sel_b}, {28'h0, r12, e12});
    check({nm, " sel16x2"}, {28'h0, err_c, sel_c}, {28'h0, r16, e16});
  endtask

  task automatic apply_vec(input int i);
    for (int j = 0; j < 16; j++) data_array[j*8 +: 8] = 8'hA0 + 8'(j);
    mode          = vecs[i].mode;
    base          = vecs[i].base;
    address_array = vecs[i].adr;
  endtask

  task automatic check_idle(input string nm);
    check(nm, {busy_a, done_a, sel_a, err_a, busy_b, done_b, sel_b, err_b},
          64'h0);
    check({nm, "_c"}, {26'h0, busy_c, done_c, sel_c, err_c}, 64'h0);
  endtask

  initial begin
    logic [31:0] s16, s12;
    logic [3:0]  r16, r12;
    int da, dc, na2, nc2, any_done;

    vecs[0] = '{1'b0, 4'd0,  16'h70F3, 32'hA7A0AFA3, 4'b0000, 32'hA7A000A3, 4'b0010};
    vecs[1] = '{1'b1, 4'd3,  16'h0F1E, 32'hA3A2A4A1, 4'b0000, 32'hA300A400, 4'b0101};
    vecs[2] = '{1'b0, 4'd0,  16'h5FCB, 32'hA5AFACAB, 4'b0000, 32'hA50000AB, 4'b0110};
    vecs[3] = '{1'b1, 4'd7,  16'h925B, 32'hA0A9ACA2, 4'b0000, 32'hA4A9A0A6, 4'b0000};
    vecs[4] = '{1'b1, 4'd13, 16'h3210, 32'hA0AFAEAD, 4'b0000, 32'h00000000, 4'b1111};

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; base = '0; address_array = '0;
    for (int j = 0; j < 16; j++) data_array[j*8 +: 8] = 8'(j * 3);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_idle("idle_no_start");

    for (int i = 0; i < 5; i++) begin
      apply_vec(i);
      run_op($sformatf("vec%0d", i), vecs[i].sel16, vecs[i].err16,
             vecs[i].sel12, vecs[i].err12, i == 2);
      @(posedge clk); #1;
    end

    for (int n = 0; n < 20; n++) begin
      scramble();
      model(16, mode, base, address_array, data_array, s16, r16);
      model(12, mode, base, address_array, data_array, s12, r12);
      run_op($sformatf("rand%0d", n), s16, r16, s12, r12, n[0]);
    end

    // Reset between edges 2 and 3 of an operation.
    apply_vec(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle("midrun_reset");
    any_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst_n = 1'b1;
      if (done_a || done_b || done_c) any_done++;
    end
    check("midrun_no_done", 64'(any_done), 64'd0);
    apply_vec(0);
    run_op("after_reset", vecs[0].sel16, vecs[0].err16, vecs[0].sel12, vecs[0].err12, 1'b0);

    // Held start: back-to-back operations every G+2 cycles.
    apply_vec(3);
    da = 0; dc = 0; na2 = 0; nc2 = 0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (done_a) begin na2++; if (na2 == 2) da = c; end
      if (done_c) begin nc2++; if (nc2 == 2) dc = c; end
    end
    start = 1'b0;
    check("b2b_second_done_a", 64'(da), 64'd10);
    check("b2b_second_done_c", 64'(dc), 64'd6);
    check("b2b_count", {32'(na2), 32'(nc2)}, {32'd2, 32'd3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
